// File: rtl/s713_harness_pkg.sv
// Shared definitions for the s713 response-compaction harness.
// Holds the compactor state encoding, the default vector/signature/count
// widths and the MISR feedback polynomial (CRC-32 generator).
package s713_harness_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int unsigned RESP_W_DEF = 23;
  localparam int unsigned SIG_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [31:0] POLY_DEF = 32'h04C11DB7;

endpackage : s713_harness_pkg

// File: rtl/s713_resp_misr_step.sv
// misr_step: one combinational MISR update.
//   i_misr  current signature
//   i_resp  response vector, zero-extended into the low bits
//   o_next  next signature = shift-left with POLY feedback, XOR response
// Pure GF(2) arithmetic; no state, no carries.
module misr_step #(
  parameter int unsigned          RESP_W = 23,
  parameter int unsigned          SIG_W  = 32,
  parameter logic [SIG_W-1:0]     POLY   = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0]  i_misr,
  input  logic [RESP_W-1:0] i_resp,
  output logic [SIG_W-1:0]  o_next
);

  logic [SIG_W-1:0] w_shift;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_resp_ext;

  assign w_shift    = {i_misr[SIG_W-2:0], 1'b0};
  // Feedback taps apply only when the bit shifted out is set.
  assign w_fb       = i_misr[SIG_W-1] ? POLY : {SIG_W{1'b0}};
  assign w_resp_ext = {{(SIG_W-RESP_W){1'b0}}, i_resp};
  assign o_next     = w_shift ^ w_fb ^ w_resp_ext;

endmodule : misr_step

// File: rtl/s713_resp_misr.sv
// s713_resp_misr: compacts the 23 s713 primary outputs into a 32-bit MISR
// signature over a programmed number of accepted vectors, then offers the
// signature on a valid/ready handshake.
// Ports:
//   CK          clock, rising edge
//   RST         synchronous active-high reset; aborts any run
//   start       begin a run (IDLE only)
//   num_cycles  vectors to compact, sampled with start
//   seed        initial signature, sampled with start
//   resp_in     s713 output vector
//   resp_valid  resp_in is to be compacted this cycle
//   busy        run in progress (COMPACT or HOLD)
//   sig_out     signature, stable while sig_valid
//   sig_valid   signature available
//   sig_ready   consumer takes the signature
//   cnt_out     vectors accepted in the current/last run
module s713_resp_misr
  import s713_harness_pkg::*;
#(
  parameter int unsigned      RESP_W = RESP_W_DEF,
  parameter int unsigned      SIG_W  = SIG_W_DEF,
  parameter int unsigned      CNT_W  = CNT_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = POLY_DEF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic [SIG_W-1:0]  seed,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_valid,
  output logic              busy,
  output logic [SIG_W-1:0]  sig_out,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [CNT_W-1:0]  cnt_out
);

  state_e           r_state;
  logic [SIG_W-1:0] r_misr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_target;
  logic             r_busy;
  logic             r_sig_valid;

  state_e           w_state_nxt;
  logic [SIG_W-1:0] w_misr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_target_nxt;
  logic [SIG_W-1:0] w_misr_step;
  logic [CNT_W-1:0] w_count_inc;

  misr_step #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY)
  ) u_step (
    .i_misr (r_misr),
    .i_resp (resp_in),
    .o_next (w_misr_step)
  );

  assign w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, next-signature and counter decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_misr_nxt   = r_misr;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_misr_nxt   = seed;
          w_count_nxt  = {CNT_W{1'b0}};
          w_target_nxt = num_cycles;
          // A zero-length run presents the seed itself as the signature.
          if (num_cycles == {CNT_W{1'b0}}) begin
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = COMPACT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COMPACT: begin
        if (resp_valid) begin
          w_misr_nxt  = w_misr_step;
          w_count_nxt = w_count_inc;
          // The last vector still folds in; the signature is ready next cycle.
          if (w_count_inc == r_target) begin
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = COMPACT;
          end
        end else begin
          w_state_nxt = COMPACT;
        end
      end
      HOLD: begin
        if (sig_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, signature, counter and registered status flags.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_misr      <= {SIG_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_target    <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_misr      <= w_misr_nxt;
      r_count     <= w_count_nxt;
      r_target    <= w_target_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_sig_valid <= (w_state_nxt == HOLD);
    end
  end

  assign busy      = r_busy;
  assign sig_valid = r_sig_valid;
  assign sig_out   = r_misr;
  assign cnt_out   = r_count;

endmodule : s713_resp_misr

// File: tb/tb_s713_resp_misr.sv
// Self-checking bench for s713_resp_misr: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_s713_resp_misr;

  localparam logic [31:0] TB_POLY = 32'h04C11DB7;

  logic        CK;
  logic        RST;
  logic        start;
  logic [15:0] num_cycles;
  logic [31:0] seed;
  logic [22:0] resp_in;
  logic        resp_valid;
  logic        busy;
  logic [31:0] sig_out;
  logic        sig_valid;
  logic        sig_ready;
  logic [15:0] cnt_out;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  s713_resp_misr dut (
    .CK         (CK),
    .RST        (RST),
    .start      (start),
    .num_cycles (num_cycles),
    .seed       (seed),
    .resp_in    (resp_in),
    .resp_valid (resp_valid),
    .busy       (busy),
    .sig_out    (sig_out),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .cnt_out    (cnt_out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signature polynomial arithmetic: multiply by x modulo POLY, add response.
  function automatic logic [31:0] model_step(input logic [31:0] m, input logic [22:0] r);
    logic [31:0] v;
    v = m << 1;
    if (m[31]) v = v ^ TB_POLY;
    return v ^ {9'd0, r};
  endfunction

  // Behavioural model: running / holding flags, signature, accept count.
  logic        m_busy   = 1'b0;
  logic        m_hold   = 1'b0;
  logic [31:0] m_sig    = 32'd0;
  logic [15:0] m_cnt    = 16'd0;
  logic [15:0] m_target = 16'd0;
  int          m_acc    = 0;

  always @(posedge CK) begin
    if (RST) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_sig <= 32'd0; m_cnt <= 16'd0; m_target <= 16'd0;
    end else if (!m_busy) begin
      if (start) begin
        m_sig <= seed; m_cnt <= 16'd0; m_target <= num_cycles; m_busy <= 1'b1;
        m_hold <= (num_cycles == 16'd0);
      end
    end else if (!m_hold) begin
      if (resp_valid) begin
        m_sig <= model_step(m_sig, resp_in);
        m_cnt <= m_cnt + 16'd1;
        m_acc <= m_acc + 1;
        if (m_cnt + 16'd1 == m_target) m_hold <= 1'b1;
      end
    end else if (sig_ready) begin
      m_busy <= 1'b0; m_hold <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CK) begin
    if (chk_on) begin
      check("cmp_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cmp_sig_valid", {31'd0, sig_valid}, {31'd0, m_hold});
      check("cmp_sig_out", sig_out, m_sig);
      check("cmp_cnt_out", {16'd0, cnt_out}, {16'd0, m_cnt});
    end
  end

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!sig_valid && n < budget) begin
      resp_in = 23'($urandom);
      @(negedge CK);
      n++;
    end
    check(name, {31'd0, sig_valid}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_stage;
    int runs;
    int cyc;
    RST = 1'b1; start = 1'b0; num_cycles = 16'd0; seed = 32'd0;
    resp_in = 23'd0; resp_valid = 1'b0; sig_ready = 1'b0;
    @(negedge CK);
    chk_on = 1'b1;
    @(negedge CK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    check("rst_sig_out", sig_out, 32'd0);
    check("rst_cnt", {16'd0, cnt_out}, 32'd0);
    RST = 1'b0;

    // 1: single vector from zero seed, valid two cycles after start
    seed = 32'd0; num_cycles = 16'd1; resp_in = 23'h000001; resp_valid = 1'b1; start = 1'b1;
    @(negedge CK); start = 1'b0;
    check("t1_not_yet", {31'd0, sig_valid}, 32'd0);
    @(negedge CK);
    check("t1_valid", {31'd0, sig_valid}, 32'd1);
    check("t1_sig", sig_out, 32'h00000001);
    check("t1_cnt", {16'd0, cnt_out}, 32'd1);
    sig_ready = 1'b1;
    @(negedge CK); sig_ready = 1'b0; resp_valid = 1'b0;
    check("t1_drop", {31'd0, sig_valid}, 32'd0);

    // 2: feedback path
    seed = 32'h80000000; num_cycles = 16'd1; resp_in = 23'd0; resp_valid = 1'b1; start = 1'b1;
    @(negedge CK); start = 1'b0;
    @(negedge CK);
    check("t2_sig", sig_out, 32'h04C11DB7);
    sig_ready = 1'b1;
    @(negedge CK); sig_ready = 1'b0; resp_valid = 1'b0;

    // 3: bubble between two vectors
    seed = 32'd0; num_cycles = 16'd2; resp_in = 23'h000001; resp_valid = 1'b1; start = 1'b1;
    @(negedge CK); start = 1'b0;
    @(negedge CK); resp_valid = 1'b0;
    check("t3_cnt1", {16'd0, cnt_out}, 32'd1);
    @(negedge CK);
    check("t3_bubble_cnt", {16'd0, cnt_out}, 32'd1);
    resp_in = 23'd0; resp_valid = 1'b1;
    @(negedge CK);
    check("t3_valid", {31'd0, sig_valid}, 32'd1);
    check("t3_sig", sig_out, 32'h00000002);
    check("t3_cnt2", {16'd0, cnt_out}, 32'd2);
    sig_ready = 1'b1;
    @(negedge CK); sig_ready = 1'b0; resp_valid = 1'b0;

    // 4: zero-length run, long hold, ignored start
    seed = 32'hDEADBEEF; num_cycles = 16'd0; start = 1'b1;
    @(negedge CK); start = 1'b0;
    check("t4_valid", {31'd0, sig_valid}, 32'd1);
    check("t4_sig", sig_out, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; seed = 32'h12345678; num_cycles = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge CK);
      check("t4_hold_valid", {31'd0, sig_valid}, 32'd1);
      check("t4_hold_sig", sig_out, 32'hDEADBEEF);
    end
    start = 1'b0; sig_ready = 1'b1;
    @(negedge CK); sig_ready = 1'b0;
    check("t4_idle", {31'd0, busy}, 32'd0);

    // 5: reset after 3 of 10 accepts
    seed = 32'h00C0FFEE; num_cycles = 16'd10; start = 1'b1; resp_valid = 1'b0;
    @(negedge CK); start = 1'b0; resp_valid = 1'b1;
    repeat (3) begin
      resp_in = 23'($urandom);
      @(negedge CK);
    end
    resp_valid = 1'b0;
    check("t5_cnt3", {16'd0, cnt_out}, 32'd3);
    RST = 1'b1;
    @(negedge CK); RST = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_valid", {31'd0, sig_valid}, 32'd0);
    check("t5_sig", sig_out, 32'd0);
    check("t5_cnt", {16'd0, cnt_out}, 32'd0);
    seed = $urandom; num_cycles = 16'd4; start = 1'b1;
    @(negedge CK); start = 1'b0; resp_valid = 1'b1;
    wait_valid("t5_rerun_timeout", 20);
    check("t5_rerun_cnt", {16'd0, cnt_out}, 32'd4);
    sig_ready = 1'b1;
    @(negedge CK); sig_ready = 1'b0; resp_valid = 1'b0;

    // 6: random back-to-back runs with start held high
    gap_stage = 0; runs = 0; cyc = 0;
    start = 1'b1;
    while (m_acc < 1000 && cyc < 20000) begin
      if (gap_stage == 1) begin
        check("t6_idle_gap", {31'd0, busy}, 32'd0);
        gap_stage = 2;
      end else if (gap_stage == 2) begin
        check("t6_restart", {31'd0, busy}, 32'd1);
        gap_stage = 0;
      end
      num_cycles = 16'($urandom_range(0, 40));
      seed       = $urandom;
      resp_in    = 23'($urandom);
      resp_valid = 1'($urandom_range(0, 1));
      sig_ready  = ($urandom_range(0, 3) != 0);
      if (sig_valid && sig_ready) begin
        gap_stage = 1;
        runs++;
      end
      @(negedge CK);
      cyc++;
    end
    check("t6_accepts", {31'd0, (m_acc >= 1000)}, 32'd1);
    check("t6_runs", {31'd0, (runs > 10)}, 32'd1);
    start = 1'b0; sig_ready = 1'b1; resp_valid = 1'b1;
    repeat (50) @(negedge CK);
    check("t6_drain", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_s713_resp_misr

// File: doc/s713_resp_misr.md
Name: s713_resp_misr

Overview:
- Downstream response compactor for the s713 sequential core.
- Consumes the 23 primary outputs of s713, one vector per accepted cycle, over a programmed number of cycles.
- Folds the vectors into a 32-bit MISR signature and returns it to the test/attack harness over a valid/ready handshake.
- Used to compare oracle and locked-netlist behaviour over long sequences without capturing every output vector.

Parameters:
- RESP_W, 23, width of the s713 output vector. Bit order, LSB first: G103BF, G104BF, G105BF, G106BF, G107, G83, G84, G85, G86BF, G87BF, G88BF, G89BF, G90, G91, G92, G94, G95BF, G96BF, G97BF, G98BF, G99BF, G100BF, G101BF.
- SIG_W, 32, signature width; must be >= RESP_W.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- CNT_W, 16, width of the cycle count.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin a compaction run; honoured only in IDLE.
- num_cycles  in  CNT_W  number of vectors to compact; sampled on an accepted start.
- seed  in  SIG_W  initial signature; sampled on an accepted start.
- resp_in  in  RESP_W  s713 output vector.
- resp_valid  in  1  resp_in holds a vector to compact this cycle.
- busy  out  1  high in COMPACT and HOLD.
- sig_out  out  SIG_W  signature; stable while sig_valid is high.
- sig_valid  out  1  signature available.
- sig_ready  in  1  consumer accepts the signature.
- cnt_out  out  CNT_W  number of vectors accepted in the current run.

Behaviour:
- Reset: RST sampled high forces state=IDLE, misr=0, count=0, target=0. All outputs read 0 the cycle after. Reset in any state aborts the run; no signature is emitted.
- States: IDLE, COMPACT, HOLD.
- IDLE, start=1:
  - misr <= seed, count <= 0, target <= num_cycles.
  - If num_cycles==0, go to HOLD (signature = seed). Otherwise go to COMPACT.
- IDLE, start=0: hold all state.
- COMPACT:
  - A vector is accepted on each cycle with resp_valid=1. Cycles with resp_valid=0 leave misr and count unchanged; there is no timeout.
  - Step on accept: misr <= {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
  - count increments on each accept.
  - When an accept occurs with count==target-1, the MISR update still happens and the state moves to HOLD.
- HOLD:
  - sig_valid=1 and sig_out=misr, registered, with no gap after the final accept.
  - resp_valid is ignored.
  - sig_valid && sig_ready returns to IDLE in the same edge; sig_valid drops the next cycle.
  - The signature may sit indefinitely without sig_ready.
- start outside IDLE is ignored: no restart, no error.
- start in the cycle after the HOLD->IDLE handshake is accepted, so back-to-back runs have a 1-cycle IDLE gap.
- Latency:
  - First accept can occur the cycle after start.
  - Signature is valid 1 cycle after the final accepted vector.
  - A run of N vectors with resp_valid held high takes N+1 cycles from start to sig_valid.
- Arithmetic:
  - count wraps never, since target <= 2^CNT_W - 1.
  - The MISR is pure GF(2); no carries.
  - sig_out holds the last signature in IDLE until the next start; sig_valid qualifies it.
- busy = (state != IDLE).
- cnt_out = count, which holds its final value in HOLD and IDLE.

Decomposition:
- Package s713_harness_pkg holds:
  - state enum (IDLE=2'd0, COMPACT=2'd1, HOLD=2'd2);
  - RESP_W, SIG_W, CNT_W defaults;
  - the POLY constant.
- Sub-module misr_step: purely combinational next-signature function (misr, resp, POLY -> next).
  - Kept separate so the bench can call the same function in its reference model.
- The FSM, counter and handshake live in s713_resp_misr.

Test Plan:
1. Reset, then seed=0, num_cycles=1, resp_in=23'h000001 with resp_valid high -> sig_valid 2 cycles after start, sig_out=32'h00000001, cnt_out=1.
2. seed=32'h80000000, num_cycles=1, resp_in=0 -> sig_out=32'h04C11DB7.
3. seed=0, num_cycles=2, vectors 23'h000001 then 23'h000000, with a resp_valid=0 bubble between them -> sig_out=32'h00000002, cnt_out=2. The bubble must not advance the count.
4. num_cycles=0, seed=32'hDEADBEEF -> HOLD the cycle after start with sig_out=32'hDEADBEEF. Hold sig_ready low for 5 cycles: sig_valid stays high and sig_out stays stable. Pulsing start during the hold has no effect.
5. RST pulse mid-COMPACT after 3 of 10 accepts -> next cycle busy=0, sig_valid=0, sig_out=0, cnt_out=0. A subsequent run matches the model from a fresh seed.
6. 1000 random s713 output vectors, random resp_valid and sig_ready -> sig_out equals the misr_step reference model. Check with back-to-back runs, verifying the 1-cycle IDLE gap.
